// File: rtl/lifo_arb_pkg.sv
// Shared constants and types for the two-client LIFO arbiter.
package lifo_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    localparam logic CL_A = 1'b0;
    localparam logic CL_B = 1'b1;

    typedef struct packed {
        logic id;
        logic op;
        logic rej;
    } txn_t;

    function automatic logic is_reject(input logic op, input logic full, input logic empty);
        return (op == OP_PUSH) ? full : empty;
    endfunction

endpackage

// File: rtl/lifo_arb_rr.sv
// Two-way request picker; round-robin by default, fixed A priority with LIFO_ARB_PRIO_EN.
module lifo_arb_rr
    import lifo_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic update,
    input  logic win,
    output logic grant
);

`ifdef LIFO_ARB_PRIO_EN
    logic unused_rr;
    assign unused_rr = ^{clk, rst, req_b, update, win};

    always_comb begin
        grant = req_a ? CL_A : CL_B;
    end
`else
    logic last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= CL_B;
        end else if (update) begin
            last_q <= win;
        end
    end

    always_comb begin
        if (req_a && req_b) begin
            grant = ~last_q;
        end else if (req_a) begin
            grant = CL_A;
        end else begin
            grant = CL_B;
        end
    end
`endif

endmodule

// File: rtl/lifo_arbiter.sv
// Serialises push/pop requests from clients A and B onto a single LIFO.
// Define LIFO_ARB_PRIO_EN for fixed A-over-B priority instead of round-robin.
module lifo_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          op_a,
    input  logic [DW-1:0] wdata_a,
    output logic          ack_a,
    output logic          err_a,
    output logic          rvalid_a,
    output logic [DW-1:0] rdata_a,
    input  logic          req_b,
    input  logic          op_b,
    input  logic [DW-1:0] wdata_b,
    output logic          ack_b,
    output logic          err_b,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata_b,
    output logic [DW-1:0] lifo_in,
    output logic          lifo_wn,
    output logic          lifo_rn,
    input  logic [DW-1:0] lifo_out,
    input  logic          lifo_full,
    input  logic          lifo_empty,
    output logic          busy
);

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    logic [1:0]    state_q, state_d;
    txn_t          txn_q;
    logic [DW-1:0] data_q;
    logic [1:0]    cnt_q;
    logic          req_av, req_bv, any_req;
    logic          gnt, gnt_op, gnt_rej, issue_go;
    logic [DW-1:0] gnt_data;
    logic          in_resp, resp_a, resp_b, rd_capture;

    // A client whose ack is showing still holds req this cycle; do not serve it twice.
    assign req_av  = req_a & ~ack_a;
    assign req_bv  = req_b & ~ack_b;
    assign any_req = req_av | req_bv;

    lifo_arb_rr u_rr (
        .clk    (clk),
        .rst    (rst),
        .req_a  (req_av),
        .req_b  (req_bv),
        .update (in_resp),
        .win    (txn_q.id),
        .grant  (gnt)
    );

    assign gnt_op   = (gnt == CL_B) ? op_b : op_a;
    assign gnt_data = (gnt == CL_B) ? wdata_b : wdata_a;
    assign gnt_rej  = is_reject(gnt_op, lifo_full, lifo_empty);
    assign issue_go = (state_q == ST_IDLE) && any_req && !gnt_rej;

    assign in_resp    = (state_q == ST_RESP);
    assign resp_a     = in_resp && (txn_q.id == CL_A);
    assign resp_b     = in_resp && (txn_q.id == CL_B);
    assign rd_capture = (state_q == ST_WAIT) && (cnt_q == 2'd0);

    assign lifo_in = data_q;
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req) state_d = gnt_rej ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_d = (txn_q.op == OP_PUSH) ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (cnt_q == 2'd0) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            txn_q    <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            lifo_wn  <= 1'b0;
            lifo_rn  <= 1'b0;
            ack_a    <= 1'b0;
            err_a    <= 1'b0;
            rvalid_a <= 1'b0;
            rdata_a  <= '0;
            ack_b    <= 1'b0;
            err_b    <= 1'b0;
            rvalid_b <= 1'b0;
            rdata_b  <= '0;
        end else begin
            state_q <= state_d;

            if ((state_q == ST_IDLE) && any_req) begin
                txn_q.id  <= gnt;
                txn_q.op  <= gnt_op;
                txn_q.rej <= gnt_rej;
                data_q    <= gnt_data;
            end

            if (state_q == ST_ISSUE) begin
                cnt_q <= CNT_INIT;
            end else if ((state_q == ST_WAIT) && (cnt_q != 2'd0)) begin
                cnt_q <= cnt_q - 2'd1;
            end

            // Strobes are registered from the grant so they are high exactly in ISSUE.
            lifo_wn <= issue_go && (gnt_op == OP_PUSH);
            lifo_rn <= issue_go && (gnt_op == OP_POP);

            if (rd_capture) begin
                if (txn_q.id == CL_A) begin
                    rdata_a <= lifo_out;
                end else begin
                    rdata_b <= lifo_out;
                end
            end

            ack_a    <= resp_a;
            err_a    <= resp_a && txn_q.rej;
            rvalid_a <= resp_a && !txn_q.rej && (txn_q.op == OP_POP);
            ack_b    <= resp_b;
            err_b    <= resp_b && txn_q.rej;
            rvalid_b <= resp_b && !txn_q.rej && (txn_q.op == OP_POP);
        end
    end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Self-checking bench for lifo_arbiter: directed vectors, tie/reset sequences, random vs model.
module tb_lifo_arbiter;

    localparam int DEPTH = 4;
    localparam int NV    = 13;
    localparam int RND   = 600;

    typedef struct {
        logic       cl;
        logic       op;
        logic [7:0] wd;
        logic       err;
        logic       rv;
        logic [7:0] rd;
        int         lat;
    } vec_t;

    logic       clk, rst;
    logic       req_a, op_a, req_b, op_b;
    logic [7:0] wdata_a, wdata_b;
    logic       ack_a, err_a, rvalid_a, ack_b, err_b, rvalid_b;
    logic [7:0] rdata_a, rdata_b;
    logic [7:0] lifo_in, lifo_out;
    logic       lifo_wn, lifo_rn, lifo_full, lifo_empty, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wn_cnt = 0, rn_cnt = 0, both_ack = 0, both_str = 0;

    lifo_arbiter #(.DW(8), .RD_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_a      (req_a),
        .op_a       (op_a),
        .wdata_a    (wdata_a),
        .ack_a      (ack_a),
        .err_a      (err_a),
        .rvalid_a   (rvalid_a),
        .rdata_a    (rdata_a),
        .req_b      (req_b),
        .op_b       (op_b),
        .wdata_b    (wdata_b),
        .ack_b      (ack_b),
        .err_b      (err_b),
        .rvalid_b   (rvalid_b),
        .rdata_b    (rdata_b),
        .lifo_in    (lifo_in),
        .lifo_wn    (lifo_wn),
        .lifo_rn    (lifo_rn),
        .lifo_out   (lifo_out),
        .lifo_full  (lifo_full),
        .lifo_empty (lifo_empty),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small behavioural LIFO, reset together with the arbiter; pop data appears one cycle later.
    logic [7:0] mem [DEPTH];
    int         lcnt;
    assign lifo_full  = (lcnt == DEPTH);
    assign lifo_empty = (lcnt == 0);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            lcnt     <= 0;
            lifo_out <= 8'd0;
        end else if (lifo_wn && lcnt < DEPTH) begin
            mem[lcnt] <= lifo_in;
            lcnt      <= lcnt + 1;
        end else if (lifo_rn && lcnt > 0) begin
            lifo_out <= mem[lcnt-1];
            lcnt     <= lcnt - 1;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lifo_wn) wn_cnt <= wn_cnt + 1;
        if (lifo_rn) rn_cnt <= rn_cnt + 1;
        if (lifo_wn && lifo_rn) both_str <= both_str + 1;
    end

    always @(negedge clk) begin
        if (ack_a && ack_b) both_ack <= both_ack + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic pick(input logic ra, input logic rb, input logic last);
`ifdef LIFO_ARB_PRIO_EN
        return ra ? 1'b0 : 1'b1;
`else
        if (ra && rb) return ~last;
        return ra ? 1'b0 : 1'b1;
`endif
    endfunction

    task automatic do_txn(input logic cl, input logic op, input logic [7:0] wd, output int lat,
                          output logic err, output logic rv, output logic [7:0] rd);
        int   n;
        logic got;
        @(negedge clk);
        if (cl) begin req_b = 1'b1; op_b = op; wdata_b = wd; end
        else    begin req_a = 1'b1; op_a = op; wdata_a = wd; end
        n = 0; got = 1'b0; err = 1'b0; rv = 1'b0; rd = 8'd0;
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if ((cl ? ack_b : ack_a) == 1'b1) begin
                got = 1'b1;
                err = cl ? err_b : err_a;
                rv  = cl ? rvalid_b : rvalid_a;
                rd  = cl ? rdata_b : rdata_a;
            end
        end
        lat = got ? n : -1;
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic pair(input string tag, input logic opa, input logic [7:0] wda, input logic opb,
                        input int exp_first, input logic [7:0] rda, input logic [7:0] rdb);
        int   n, first;
        logic done_a, done_b, drop_a, drop_b;
        @(negedge clk);
        req_a = 1'b1; op_a = opa; wdata_a = wda;
        req_b = 1'b1; op_b = opb; wdata_b = 8'd0;
        n = 0; first = -1; done_a = 0; done_b = 0; drop_a = 0; drop_b = 0;
        while (!(done_a && done_b) && n < 60) begin
            @(negedge clk);
            n++;
            if (drop_a) begin req_a = 1'b0; drop_a = 1'b0; end
            if (drop_b) begin req_b = 1'b0; drop_b = 1'b0; end
            if (ack_a && !done_a) begin
                done_a = 1'b1; drop_a = 1'b1;
                if (first < 0) first = 0;
                chk({tag, "_rvalid_a"}, rvalid_a, (opa == 1'b0));
                if (opa == 1'b0) chk({tag, "_rdata_a"}, rdata_a, rda);
            end
            if (ack_b && !done_b) begin
                done_b = 1'b1; drop_b = 1'b1;
                if (first < 0) first = 1;
                chk({tag, "_rvalid_b"}, rvalid_b, (opb == 1'b0));
                if (opb == 1'b0) chk({tag, "_rdata_b"}, rdata_b, rdb);
            end
        end
        chk({tag, "_done"}, {done_a, done_b}, 2'b11);
        chk({tag, "_first"}, first, exp_first);
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    vec_t       tbl [NV];
    int         lat, w0, r0, k, n;
    logic       e, v;
    logic [7:0] d, exp_rd;
    int         ord [6];

    // Random-phase model state
    logic [7:0] stk [$];
    int         next_s, ack_c, rd_c, busy_u, ph_a, ph_b, lt;
    logic       pw, pe, pr, rd_w, last, ea, eb, infl_a, infl_b, ra, rb, w, o, rej;
    logic [7:0] rd_v, erd_a, erd_b, dd;

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 8'd100, 1'b0, 1'b0, 8'd0,   3};
        tbl[1]  = '{1'b0, 1'b1, 8'd150, 1'b0, 1'b0, 8'd0,   3};
        tbl[2]  = '{1'b0, 1'b1, 8'd200, 1'b0, 1'b0, 8'd0,   3};
        tbl[3]  = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 8'd200, 4};
        tbl[4]  = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 8'd150, 4};
        tbl[5]  = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 8'd100, 4};
        tbl[6]  = '{1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 8'd0,   2};
        tbl[7]  = '{1'b0, 1'b1, 8'd1,   1'b0, 1'b0, 8'd0,   3};
        tbl[8]  = '{1'b1, 1'b1, 8'd2,   1'b0, 1'b0, 8'd0,   3};
        tbl[9]  = '{1'b0, 1'b1, 8'd3,   1'b0, 1'b0, 8'd0,   3};
        tbl[10] = '{1'b1, 1'b1, 8'd4,   1'b0, 1'b0, 8'd0,   3};
        tbl[11] = '{1'b0, 1'b1, 8'd5,   1'b1, 1'b0, 8'd0,   2};
        tbl[12] = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 8'd4,   4};

        rst = 1'b0;
        req_a = 1'b0; op_a = 1'b0; wdata_a = 8'd0;
        req_b = 1'b0; op_b = 1'b0; wdata_b = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {ack_a, ack_b, err_a, err_b, rvalid_a, rvalid_b, lifo_wn, lifo_rn, busy},
            9'd0);
        chk("reset_data", {rdata_a, rdata_b, lifo_in}, 24'd0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            w0 = wn_cnt;
            r0 = rn_cnt;
            do_txn(tbl[i].cl, tbl[i].op, tbl[i].wd, lat, e, v, d);
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d_err", i), e, tbl[i].err);
            chk($sformatf("vec%0d_rvalid", i), v, tbl[i].rv);
            if (tbl[i].rv) chk($sformatf("vec%0d_rdata", i), d, tbl[i].rd);
            chk($sformatf("vec%0d_wn", i), wn_cnt - w0, (!tbl[i].err && tbl[i].op));
            chk($sformatf("vec%0d_rn", i), rn_cnt - r0, (!tbl[i].err && !tbl[i].op));
            if (i == 2) chk("push3_wn_total", wn_cnt, 3);
        end

        // Last grant was B: A wins the tie in either build. Stack holds 1,2,3.
        pair("tie1", 1'b1, 8'd40, 1'b0, 0, 8'd0, 8'd40);
        do_txn(1'b0, 1'b1, 8'd7, lat, e, v, d);
        chk("push7_lat", lat, 3);
        // Last grant was A: round-robin favours B, fixed priority still picks A.
`ifdef LIFO_ARB_PRIO_EN
        pair("tie2", 1'b0, 8'd0, 1'b0, 0, 8'd7, 8'd3);
`else
        pair("tie2", 1'b0, 8'd0, 1'b0, 1, 8'd3, 8'd7);
`endif

        // Reset while a pop sits in WAIT.
        @(negedge clk);
        req_b = 1'b1; op_b = 1'b0; wdata_b = 8'd0;
        @(posedge clk);
        #1 chk("rst_issue_rn", lifo_rn, 1'b1);
        @(posedge clk);
        #1 chk("rst_wait_busy", busy, 1'b1);
        rst = 1'b0;
        #1 chk("rst_async_out", {lifo_rn, lifo_wn, ack_a, ack_b, busy}, 5'd0);
        req_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("rst_rdata_b", rdata_b, 8'd0);
        do_txn(1'b0, 1'b1, 8'd55, lat, e, v, d);
        chk("post_rst_push_lat", lat, 3);
        chk("post_rst_push_err", e, 1'b0);
        do_txn(1'b1, 1'b0, 8'd0, lat, e, v, d);
        chk("post_rst_pop_lat", lat, 4);
        chk("post_rst_pop", {e, v, d}, {1'b0, 1'b1, 8'd55});

        // Both clients hold req: A pushes, B pops, grants must alternate starting with A.
        for (int i = 0; i < 6; i++) ord[i] = 9;
        @(negedge clk);
        req_a = 1'b1; op_a = 1'b1; wdata_a = 8'd11;
        req_b = 1'b1; op_b = 1'b0;
        k = 0; n = 0; exp_rd = 8'd0;
        while (k < 6 && n < 100) begin
            @(negedge clk);
            n++;
            if (ack_a && k < 6) begin
                ord[k] = 0; k++;
                exp_rd = wdata_a;
                wdata_a = wdata_a + 8'd11;
            end
            if (ack_b && k < 6) begin
                ord[k] = 1; k++;
                chk("cont_pop", {rvalid_b, rdata_b}, {1'b1, exp_rd});
            end
        end
        chk("cont_count", k, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("cont_order%0d", i), ord[i], i % 2);
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (10) @(negedge clk);

        // Fresh reset, then random traffic against a transaction-level model.
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        next_s = cyc + 2; ack_c = -10; rd_c = -10; busy_u = -10;
        last = 1'b1; erd_a = 8'd0; erd_b = 8'd0; rd_v = 8'd0; rd_w = 1'b0;
        pw = 1'b0; pe = 1'b0; pr = 1'b0; ph_a = 0; ph_b = 0; infl_a = 0; infl_b = 0;
        stk.delete();
        repeat (RND) begin
            @(negedge clk);
            n = cyc;
            if (n == rd_c) begin
                if (rd_w) erd_b = rd_v; else erd_a = rd_v;
            end
            ea = (n == ack_c) && !pw;
            eb = (n == ack_c) && pw;
            chk("rnd_ctl", {ack_a, ack_b, err_a, err_b, rvalid_a, rvalid_b, busy},
                {ea, eb, ea && pe, eb && pe, ea && pr, eb && pr, n <= busy_u});
            chk("rnd_rdata", {rdata_a, rdata_b}, {erd_a, erd_b});

            if (ea) begin
                ph_a = 2; infl_a = 0;
            end else if (ph_a != 1) begin
                if ((ph_a == 2) ? ($urandom_range(1) == 1) : ($urandom_range(2) == 0)) begin
                    req_a = 1'b1; op_a = 1'($urandom_range(1)); wdata_a = 8'($urandom); ph_a = 1;
                end else begin
                    req_a = 1'b0; ph_a = 0;
                end
            end else if (infl_a) begin
                op_a = 1'($urandom_range(1)); wdata_a = 8'($urandom);
            end
            if (eb) begin
                ph_b = 2; infl_b = 0;
            end else if (ph_b != 1) begin
                if ((ph_b == 2) ? ($urandom_range(1) == 1) : ($urandom_range(2) == 0)) begin
                    req_b = 1'b1; op_b = 1'($urandom_range(1)); wdata_b = 8'($urandom); ph_b = 1;
                end else begin
                    req_b = 1'b0; ph_b = 0;
                end
            end else if (infl_b) begin
                op_b = 1'($urandom_range(1)); wdata_b = 8'($urandom);
            end

            if (n + 1 == next_s) begin
                ra = req_a && !ea;
                rb = req_b && !eb;
                if (ra || rb) begin
                    w = pick(ra, rb, last);
                    last = w;
                    o  = w ? op_b : op_a;
                    dd = w ? wdata_b : wdata_a;
                    rej = o ? (stk.size() == DEPTH) : (stk.size() == 0);
                    lt = rej ? 2 : (o ? 3 : 4);
                    if (!rej) begin
                        if (o) begin
                            stk.push_back(dd);
                        end else begin
                            rd_v = stk.pop_back();
                            rd_w = w;
                            rd_c = n + 3;
                        end
                    end
                    pw = w; pe = rej; pr = !rej && !o;
                    ack_c  = n + lt;
                    busy_u = n + lt - 1;
                    next_s = n + 1 + lt;
                    if (w) infl_b = 1'b1; else infl_a = 1'b1;
                end else begin
                    next_s = n + 2;
                end
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (8) @(negedge clk);

        chk("never_both_ack", both_ack, 0);
        chk("never_both_strobe", both_str, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
